uart_tx: RTL and testbench
==========================

# uart_tx

Byte-wide, transmit-only UART for the riscv32 SoC. Serialises one byte per request as an 8N1 frame on `txd` at a fixed baud rate derived from the system clock. It is memory-mapped at `uart_address`: the top level asserts `tx_data_ready` on a core store to that address. `xfer_done` feeds the core's `data_ready`, so it stays high whenever the transmitter can accept a byte.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 104: system clocks per bit (12 MHz / 115200 baud, rounded down); legal range ≥2.

Ports:
- `hs_clk`  in  1  system clock (12 MHz); the only clock. One clock; reset is synchronous and active-high.
- `reset`  in  1  reset, active-high, sampled on the rising edge of `hs_clk`.
- `tx_data`  in  8  byte to send; bit 0 is transmitted first.
- `tx_data_ready`  in  1  write strobe; a byte is accepted on any rising edge where this and `xfer_done` are both 1.
- `txd`  out  1  serial line; idles high. Registered output.
- `xfer_done`  out  1  1 = idle and able to accept a byte; 0 = frame in progress. Registered output.

## Operation

- Frame format (8N1): start bit (0), data bits 0..7 (LSB first), stop bit (1). Each bit lasts exactly `CLKS_PER_BIT` clocks.
- FSM states and transitions:
  - IDLE → START on accept. `tx_data` is latched into a shift register on the accepting edge.
  - START → DATA after `CLKS_PER_BIT` clocks.
  - DATA stays for 8 bit periods, shifting right once per period, then → STOP.
  - STOP → IDLE after `CLKS_PER_BIT` clocks.
- Bit counter is 3 bits; it wraps 7→0 on exit from DATA.
- Baud counter: counts 0..`CLKS_PER_BIT`-1, is cleared on every state entry, and produces a one-cycle bit-end tick.
- `tx_data_ready` while `xfer_done`=0 is ignored. The byte is dropped, there is no queuing, and the frame in flight is unaffected.
- `tx_data` is sampled only on the accepting edge; changes afterwards have no effect.
- Reset values (after any edge with `reset`=1):
  - state IDLE, `txd`=1, `xfer_done`=1, counters 0.
- Reset mid-frame aborts the frame. The line returns high on the next edge and no partial byte is resumed.
- Reset and `tx_data_ready` asserted together: reset wins and the byte is not accepted.

## Timing

- Accept on edge N: from edge N onward `txd`=0 and `xfer_done`=0. There is no extra latency cycle.
- Data bit k is driven from edge N+(k+1)·`CLKS_PER_BIT`.
- Stop bit is driven from edge N+9·`CLKS_PER_BIT`.
- `xfer_done` returns to 1 at edge N+10·`CLKS_PER_BIT`. This is the full stop bit; `txd` remains 1.
- Back-to-back frames: a request held high is accepted on the same edge `xfer_done` rises. The next start bit then begins immediately, giving a frame pitch of exactly 10·`CLKS_PER_BIT` clocks.
- Outputs never glitch: both come straight from flops.

## Structure

- Shared package `riscv_data` holds:
  - `uart_address` (32-bit constant; decided value 32'h0001_0000, outside the 16 KiB data-RAM window);
  - the `uart_state_t` enum {IDLE, START, DATA, STOP};
  - `UART_CLKS_PER_BIT`, the default used by the top level.
- One sub-module, `uart_baud_gen`: the parameterised baud counter with synchronous clear and a one-cycle `tick` output. The FSM, shift register and bit counter live in `uart_tx`.

## Test plan

Benches run with `CLKS_PER_BIT`=4 unless stated.

1. Reset release: hold `reset`=1 for 2 cycles, then release with no request. Required: `txd`=1 and `xfer_done`=1 on every cycle.
2. Single byte 8'hA5, 1-cycle strobe at edge N. Required:
   - `txd` sequence per 4-cycle period is 0,1,0,1,0,0,1,0,1,1;
   - `xfer_done`=0 exactly on cycles N..N+39 and 1 from N+40.
3. Strobe while busy: send 8'h55, strobe 8'hFF at N+10. Required: the frame is still 8'h55 and no second frame follows.
4. Back-to-back: hold strobe high with 8'h41 then 8'h42. Required:
   - the second start bit begins at edge N+40;
   - both bytes decode correctly;
   - there is no idle gap.
5. Reset mid-frame: send 8'h00 and assert `reset` at N+17. Required:
   - `txd`=1 and `xfer_done`=1 from the next edge;
   - a new strobe afterwards is accepted normally.
6. Default parameter: `CLKS_PER_BIT`=104, byte 8'h0D. Required: start-bit low lasts exactly 104 clocks and the total busy time is 1040 clocks.

Source files
------------

// File: rtl/riscv_data.sv
// Shared SoC constants and types for the memory-mapped UART transmitter.
package riscv_data;

    localparam logic [31:0] uart_address      = 32'h0001_0000;
    localparam int          UART_CLKS_PER_BIT = 104;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter 0..CLKS_PER_BIT-1 with synchronous clear; tick is high on the last count.
// No latency beyond the counter register; no backpressure, runs freely unless cleared.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmit-only UART; start bit leaves on the accepting edge, 10 bit periods per frame.
// Requests arriving while xfer_done=0 are dropped; a held request chains frames with no gap.
module uart_tx
    import riscv_data::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       hs_clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_data_ready,
    output logic       txd,
    output logic       xfer_done
);

    uart_state_t state, state_nx;
    logic [7:0]  shreg, shreg_nx;
    logic [2:0]  bit_cnt, bit_cnt_nx;
    logic        txd_nx, done_nx;
    logic        tick;

    // Holding the counter cleared while idle aligns bit periods to the accepting edge.
    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (hs_clk),
        .reset (reset),
        .clear (state == IDLE),
        .tick  (tick)
    );

    always_ff @(posedge hs_clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            txd       <= 1'b1;
            xfer_done <= 1'b1;
        end else begin
            state     <= state_nx;
            shreg     <= shreg_nx;
            bit_cnt   <= bit_cnt_nx;
            txd       <= txd_nx;
            xfer_done <= done_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bit_cnt_nx = bit_cnt;
        txd_nx     = txd;
        done_nx    = xfer_done;
        case (state)
            IDLE: begin
                txd_nx  = 1'b1;
                done_nx = 1'b1;
                if (tx_data_ready) begin
                    state_nx   = START;
                    shreg_nx   = tx_data;
                    bit_cnt_nx = '0;
                    txd_nx     = 1'b0;
                    done_nx    = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_nx = DATA;
                    txd_nx   = shreg[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_nx   = {1'b0, shreg[7:1]};
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nx = STOP;
                        txd_nx   = 1'b1;
                    end else begin
                        txd_nx   = shreg[1];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    // The edge that would raise xfer_done doubles as an accept edge.
                    if (tx_data_ready) begin
                        state_nx   = START;
                        shreg_nx   = tx_data;
                        bit_cnt_nx = '0;
                        txd_nx     = 1'b0;
                        done_nx    = 1'b0;
                    end else begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a CLKS_PER_BIT=4 instance for frame checks, a default instance for timing.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       hs_clk;
    logic       reset;
    logic [7:0] tx_data, tx_data2;
    logic       tx_data_ready, tx_data_ready2;
    logic       txd, txd2;
    logic       xfer_done, xfer_done2;

    int errors = 0;
    int checks = 0;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .hs_clk        (hs_clk),
        .reset         (reset),
        .tx_data       (tx_data),
        .tx_data_ready (tx_data_ready),
        .txd           (txd),
        .xfer_done     (xfer_done)
    );

    uart_tx dut_def (
        .hs_clk        (hs_clk),
        .reset         (reset),
        .tx_data       (tx_data2),
        .tx_data_ready (tx_data_ready2),
        .txd           (txd2),
        .xfer_done     (xfer_done2)
    );

    initial hs_clk = 1'b0;
    always #5 hs_clk = ~hs_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    // Move across one rising edge and park on the following falling edge.
    task automatic cyc();
        @(posedge hs_clk);
        @(negedge hs_clk);
    endtask

    // Expected line level i cycles after the accepting edge, 8N1, LSB first.
    function automatic logic exp_bit(input logic [7:0] b, input int i);
        int idx;
        idx = i / CPB;
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    // Entered just after the accepting edge; leaves just after edge N+40.
    task automatic run_frame(input string tag, input logic [7:0] b, input int poke_at,
                             input logic [7:0] poke_dat, input bit hold, input logic [7:0] nxt);
        for (int i = 0; i < 10*CPB; i++) begin
            chk({tag, "_txd"}, {31'd0, txd}, {31'd0, exp_bit(b, i)});
            chk({tag, "_busy"}, {31'd0, xfer_done}, 32'd0);
            tx_data_ready = hold || (i + 1 == poke_at);
            if (i + 1 == poke_at) tx_data = poke_dat;
            if (hold && i == 20) tx_data = nxt;
            cyc();
        end
    endtask

    initial begin
        int low_cnt, busy_cnt;
        reset = 1'b1;
        tx_data = 8'h00;
        tx_data_ready = 1'b0;
        tx_data2 = 8'h00;
        tx_data_ready2 = 1'b0;
        @(negedge hs_clk);

        // Reset hold and release
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("rst_txd", {31'd0, txd}, 32'd1);
            chk("rst_done", {31'd0, xfer_done}, 32'd1);
        end
        chk("rst_txd_def", {31'd0, txd2}, 32'd1);
        chk("rst_done_def", {31'd0, xfer_done2}, 32'd1);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("idle_txd", {31'd0, txd}, 32'd1);
            chk("idle_done", {31'd0, xfer_done}, 32'd1);
        end

        // Single byte A5 with a one-cycle strobe
        tx_data = 8'hA5;
        tx_data_ready = 1'b1;
        cyc();
        tx_data = 8'h00;
        run_frame("a5", 8'hA5, -1, 8'h00, 1'b0, 8'h00);
        chk("a5_done_after", {31'd0, xfer_done}, 32'd1);
        chk("a5_txd_after", {31'd0, txd}, 32'd1);

        // Strobe while busy is dropped
        tx_data = 8'h55;
        tx_data_ready = 1'b1;
        cyc();
        run_frame("busy55", 8'h55, 10, 8'hFF, 1'b0, 8'h00);
        for (int i = 0; i < 12*CPB; i++) begin
            chk("busy_no_second_txd", {31'd0, txd}, 32'd1);
            chk("busy_no_second_done", {31'd0, xfer_done}, 32'd1);
            cyc();
        end

        // Back-to-back frames with the strobe held
        tx_data = 8'h41;
        tx_data_ready = 1'b1;
        cyc();
        run_frame("b2b41", 8'h41, -1, 8'h00, 1'b1, 8'h42);
        chk("b2b_second_start", {31'd0, txd}, 32'd0);
        chk("b2b_no_gap", {31'd0, xfer_done}, 32'd0);
        run_frame("b2b42", 8'h42, -1, 8'h00, 1'b0, 8'h00);
        chk("b2b_done_after", {31'd0, xfer_done}, 32'd1);
        cyc();

        // Reset mid-frame
        tx_data = 8'h00;
        tx_data_ready = 1'b1;
        cyc();
        tx_data_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            chk("mid_txd", {31'd0, txd}, {31'd0, exp_bit(8'h00, i)});
            chk("mid_busy", {31'd0, xfer_done}, 32'd0);
            if (i == 16) reset = 1'b1;
            cyc();
        end
        chk("mid_rst_txd", {31'd0, txd}, 32'd1);
        chk("mid_rst_done", {31'd0, xfer_done}, 32'd1);
        reset = 1'b0;
        cyc();
        chk("mid_rel_txd", {31'd0, txd}, 32'd1);
        chk("mid_rel_done", {31'd0, xfer_done}, 32'd1);
        tx_data = 8'h3C;
        tx_data_ready = 1'b1;
        cyc();
        tx_data = 8'h00;
        run_frame("after_rst3c", 8'h3C, -1, 8'h00, 1'b0, 8'h00);
        chk("after_rst_done", {31'd0, xfer_done}, 32'd1);

        // Reset wins over a simultaneous strobe
        reset = 1'b1;
        tx_data = 8'h99;
        tx_data_ready = 1'b1;
        cyc();
        chk("rst_vs_req_done", {31'd0, xfer_done}, 32'd1);
        chk("rst_vs_req_txd", {31'd0, txd}, 32'd1);
        reset = 1'b0;
        tx_data_ready = 1'b0;
        cyc();
        chk("rst_vs_req_not_taken", {31'd0, xfer_done}, 32'd1);
        chk("rst_vs_req_line", {31'd0, txd}, 32'd1);

        // Default CLKS_PER_BIT=104, byte 0D
        tx_data2 = 8'h0D;
        tx_data_ready2 = 1'b1;
        cyc();
        tx_data_ready2 = 1'b0;
        chk("def_start_low", {31'd0, txd2}, 32'd0);
        low_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 2000 && txd2 == 1'b0; i++) begin
            low_cnt++;
            busy_cnt++;
            cyc();
        end
        chk("def_start_len", low_cnt, 104);
        chk("def_bit0", {31'd0, txd2}, 32'd1);
        for (int i = 0; i < 2000 && xfer_done2 == 1'b0; i++) begin
            busy_cnt++;
            cyc();
        end
        chk("def_busy_len", busy_cnt, 1040);
        chk("def_idle_line", {31'd0, txd2}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
